// File: rtl/branch_flag_resolver.sv
// branch_flag_resolver: registers ALU N/Z/C flags and resolves conditional branches over valid/ready
//   clk, rst_n                     clock, asynchronous active-low reset
//   alu_valid, alu_negative/zero/carry   incoming ALU flag update
//   br_valid/br_ready, br_cond, br_wait, br_pc, br_offset   branch request
//   res_valid/res_ready, res_taken, res_target, res_timeout   branch result
//   flags_q                        stored flags {N,Z,C}
module branch_flag_resolver #(
  parameter int ADDR_W     = 32,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic              br_wait,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic              res_timeout,
  output logic [2:0]        flags_q
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RES = 2'd2;
  logic [1:0]        state;
  logic [7:0]        wcnt;
  logic              live;
  logic [2:0]        cond_q;
  logic [ADDR_W-1:0] pc_q, off_q;
  logic              tk_now, tk_byp, imm;
  // condition codes indexed directly into a truth vector: bit k is the outcome of cond k
  function automatic logic eval(input logic [2:0] c, input logic [2:0] f);
    logic [7:0] t;
    t = {1'b0, ~f[0], f[0], ~f[2], f[2], ~f[1], f[1], 1'b1};
    return t[c];
  endfunction
  always_comb begin
    tk_now = eval(br_cond, flags_q);
    tk_byp = eval(cond_q, {alu_negative, alu_zero, alu_carry});
    imm    = !br_wait || br_cond == 3'b000 || br_cond == 3'b111;
  end
  // live keeps br_ready low while reset is held and until the first edge after release
  assign br_ready  = state == S_IDLE && live;
  assign res_valid = state == S_RES;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      live        <= 1'b0;
      cond_q      <= '0;
      pc_q        <= '0;
      off_q       <= '0;
      flags_q     <= '0;
      res_taken   <= 1'b0;
      res_target  <= '0;
      res_timeout <= 1'b0;
    end else begin
      live <= 1'b1;
      if (alu_valid) flags_q <= {alu_negative, alu_zero, alu_carry};
      case (state)
        S_IDLE: if (br_valid && br_ready) begin
          cond_q      <= br_cond;
          pc_q        <= br_pc;
          off_q       <= br_offset;
          res_timeout <= 1'b0;
          wcnt        <= '0;
          if (imm) begin
            res_taken  <= tk_now;
            res_target <= tk_now ? br_pc + br_offset : br_pc + ADDR_W'(4);
            state      <= S_RES;
          end else state <= S_WAIT;
        end
        S_WAIT: if (alu_valid) begin
          res_taken  <= tk_byp;
          res_target <= tk_byp ? pc_q + off_q : pc_q + ADDR_W'(4);
          state      <= S_RES;
        end else if (wcnt == 8'(WAIT_LIMIT - 1)) begin
          res_taken   <= 1'b0;
          res_target  <= pc_q + ADDR_W'(4);
          res_timeout <= 1'b1;
          state       <= S_RES;
        end else wcnt <= wcnt + 8'd1;
        S_RES: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_flag_resolver.sv
// tb_branch_flag_resolver: randomized and directed checks of branch_flag_resolver against a reference model
module tb_branch_flag_resolver;
  logic clk = 0, rst_n = 0;
  logic alu_valid = 0, alu_negative = 0, alu_zero = 0, alu_carry = 0;
  logic br_valid = 0, br_ready, br_wait = 0, res_valid, res_ready = 0;
  logic res_taken, res_timeout;
  logic [2:0] br_cond = 0, flags_q;
  logic [31:0] br_pc = 0, br_offset = 0, res_target;
  int n_chk = 0, n_fail = 0;
  logic [2:0] mflags = 0;
  always #5 clk = ~clk;
  branch_flag_resolver #(.ADDR_W(32), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_wait(br_wait), .br_pc(br_pc), .br_offset(br_offset),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .res_timeout(res_timeout), .flags_q(flags_q)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit ref_taken(input logic [2:0] cond, input logic [2:0] f);
    bit n = f[2], z = f[1], c = f[0];
    case (cond)
      3'd0: return 1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return c;
      3'd6: return !c;
      default: return 0;
    endcase
  endfunction
  task automatic drive_alu(input logic [2:0] f);
    alu_valid = 1;
    {alu_negative, alu_zero, alu_carry} = f;
  endtask
  task automatic set_flags(input logic [2:0] f);
    drive_alu(f);
    @(negedge clk);
    alu_valid = 0;
    mflags = f;
    check("flags_q", flags_q, f);
  endtask
  // one branch; alu_dly = cycle after acceptance carrying the ALU update (0 or >15: none)
  task automatic run_br(input logic [2:0] cond, input bit wt, input logic [31:0] pc, off,
                        input int alu_dly, input logic [2:0] af, input int hold);
    bit imm, got, tk, to;
    logic [31:0] tgt;
    check("br_ready_idle", br_ready, 1);
    imm = !wt || cond == 0 || cond == 7;
    br_valid = 1; br_cond = cond; br_wait = wt; br_pc = pc; br_offset = off;
    tk = ref_taken(cond, mflags);
    @(negedge clk);
    br_valid = 0;
    got = 0; to = 0;
    if (!imm) begin
      for (int k = 1; k <= 15; k++) begin
        check("no_early_res", res_valid, 0);
        if (k == alu_dly) drive_alu(af);
        @(negedge clk);
        alu_valid = 0;
        if (k == alu_dly) begin
          got = 1;
          mflags = af;
          break;
        end
      end
      tk = got ? ref_taken(cond, af) : 0;
      to = !got;
    end
    tgt = tk ? pc + off : pc + 32'd4;
    for (int h = 0; h <= hold; h++) begin
      check("res_valid", res_valid, 1);
      check("res_taken", res_taken, tk);
      check("res_target", res_target, tgt);
      check("res_timeout", res_timeout, to);
      check("br_ready_res", br_ready, 0);
      if (h == hold) begin
        res_ready = 1;
        br_valid = 0;
      end else begin
        br_valid = 1; br_cond = $urandom; br_wait = $urandom; br_pc = $urandom;
        if ($urandom_range(0, 1)) begin
          drive_alu(3'($urandom));
          mflags = {alu_negative, alu_zero, alu_carry};
        end
      end
      @(negedge clk);
      alu_valid = 0;
      br_valid = 0;
      res_ready = 0;
    end
    check("res_valid_drop", res_valid, 0);
    check("flags_track", flags_q, mflags);
  endtask
  initial begin
    #1;
    check("rst_br_ready", br_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_flags", flags_q, 0);
    check("rst_target", res_target, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("br_ready_post_rst", br_ready, 1);
    set_flags(3'b010);
    run_br(3'b001, 0, 32'h100, 32'h20, 0, 0, 0);
    run_br(3'b010, 1, 32'h200, 32'h40, 3, 3'b000, 0);
    run_br(3'b011, 1, 32'h300, 32'h8, 0, 0, 0);
    run_br(3'b101, 1, 32'h400, 32'h8, 15, 3'b001, 0);
    run_br(3'b100, 0, 32'h500, 32'h10, 0, 0, 5);
    run_br(3'b000, 1, 32'hFFFFFFFC, 32'h10, 0, 0, 0);
    run_br(3'b111, 0, 32'hFFFFFFFC, 32'h10, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) set_flags(3'($urandom));
      run_br(3'($urandom), 1'($urandom), $urandom, $urandom, $urandom_range(1, 17),
             3'($urandom), $urandom_range(0, 3));
    end
    set_flags(3'b111);
    br_valid = 1; br_cond = 3'b001; br_wait = 1; br_pc = 32'h600;
    @(negedge clk);
    br_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_br_ready", br_ready, 0);
    check("mid_rst_flags", flags_q, 0);
    check("mid_rst_target", res_target, 0);
    check("mid_rst_taken", res_taken, 0);
    @(negedge clk);
    rst_n = 1;
    mflags = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_rst_no_res", res_valid, 0);
    end
    check("post_rst_ready", br_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
